// File: rtl/rf_wr_arbiter_if.sv
// rtl/rf_wr_arbiter_if.sv - requester, hazard-query and regfile-write bundle for rf_wr_arbiter
interface rf_wr_arbiter_if;
    logic        WbReq;
    logic [4:0]  WbRd;
    logic [31:0] WbData;
    logic        WbAck;
    logic        MduReq;
    logic [4:0]  MduRd;
    logic [31:0] MduData;
    logic        MduAck;
    logic        IrqReq;
    logic [4:0]  IrqRd;
    logic [31:0] IrqData;
    logic        IrqAck;
    logic        Issue;
    logic [4:0]  IssueRd;
    logic [4:0]  RS1;
    logic [4:0]  RS2;
    logic        RS1Busy;
    logic        RS2Busy;
    logic        Stall;
    logic        RegWr;
    logic [4:0]  RD;
    logic [31:0] WData;

    modport master (
        output WbReq, WbRd, WbData, MduReq, MduRd, MduData,
        output IrqReq, IrqRd, IrqData, Issue, IssueRd, RS1, RS2,
        input  WbAck, MduAck, IrqAck, RS1Busy, RS2Busy, Stall, RegWr, RD, WData
    );

    modport slave (
        input  WbReq, WbRd, WbData, MduReq, MduRd, MduData,
        input  IrqReq, IrqRd, IrqData, Issue, IssueRd, RS1, RS2,
        output WbAck, MduAck, IrqAck, RS1Busy, RS2Busy, Stall, RegWr, RD, WData
    );
endinterface

// File: rtl/rf_wr_arbiter.sv
// rtl/rf_wr_arbiter.sv - regfile write-port arbiter with starvation guard; MDU busy scoreboard under RF_ARB_SCOREBOARD_EN
module rf_wr_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic           Clk,
    input  logic           Reset_n,
    rf_wr_arbiter_if.slave bus
);
    typedef enum logic {NORMAL = 1'b0, FORCE = 1'b1} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ptr_q, ptr_d;        // 0: MDU wins a tie next, 1: IRQ wins a tie next
    logic        stall_q, stall_d;
    logic        regwr_q, regwr_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wb_ack, mdu_ack, irq_ack, pick_irq, low_pending;

    // Grant selection, starvation tracking and next-state for the write register
    always_comb begin
        wb_ack      = 1'b0;
        mdu_ack     = 1'b0;
        irq_ack     = 1'b0;
        low_pending = bus.MduReq | bus.IrqReq;
        pick_irq    = (bus.MduReq && bus.IrqReq) ? ptr_q : bus.IrqReq;
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        stall_d     = 1'b0;
        regwr_d     = 1'b0;
        rd_d        = rd_q;
        wdata_d     = wdata_q;

        if (Reset_n) begin
            if (state_q == NORMAL && bus.WbReq) begin
                wb_ack = 1'b1;
            end else if (low_pending) begin
                mdu_ack = ~pick_irq;
                irq_ack = pick_irq;
            end
        end

        if (wb_ack) begin
            regwr_d = (bus.WbRd != 5'd0);
            rd_d    = bus.WbRd;
            wdata_d = bus.WbData;
        end else if (mdu_ack) begin
            regwr_d = (bus.MduRd != 5'd0);
            rd_d    = bus.MduRd;
            wdata_d = bus.MduData;
        end else if (irq_ack) begin
            regwr_d = (bus.IrqRd != 5'd0);
            rd_d    = bus.IrqRd;
            wdata_d = bus.IrqData;
        end

        // The pointer moves to whichever low-priority requester just lost out
        if (mdu_ack) begin
            ptr_d = 1'b1;
        end else if (irq_ack) begin
            ptr_d = 1'b0;
        end

        case (state_q)
            NORMAL: begin
                if (mdu_ack || irq_ack) begin
                    cnt_d = 4'd0;
                end else if (low_pending) begin
                    cnt_d = cnt_q + 4'd1;
                end
                if (cnt_d == LIMIT) begin
                    state_d = FORCE;
                    stall_d = 1'b1;
                end
            end
            FORCE: begin
                state_d = NORMAL;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State, counter, pointer and registered regfile write port
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= NORMAL;
            cnt_q   <= 4'd0;
            ptr_q   <= 1'b0;
            stall_q <= 1'b0;
            regwr_q <= 1'b0;
            rd_q    <= 5'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            stall_q <= stall_d;
            regwr_q <= regwr_d;
            rd_q    <= rd_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.WbAck  = wb_ack;
    assign bus.MduAck = mdu_ack;
    assign bus.IrqAck = irq_ack;
    assign bus.Stall  = stall_q;
    assign bus.RegWr  = regwr_q;
    assign bus.RD     = rd_q;
    assign bus.WData  = wdata_q;

`ifdef RF_ARB_SCOREBOARD_EN
    logic [31:0] busy_q, busy_d;

    // Issue marks a pending MDU destination; the MDU write-back clears it, a same-cycle issue wins
    always_comb begin
        busy_d = busy_q;
        if (mdu_ack) begin
            busy_d[bus.MduRd] = 1'b0;
        end
        if (bus.Issue && bus.IssueRd != 5'd0) begin
            busy_d[bus.IssueRd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard storage
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            busy_q <= 32'd0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign bus.RS1Busy = (bus.RS1 != 5'd0) && busy_q[bus.RS1];
    assign bus.RS2Busy = (bus.RS2 != 5'd0) && busy_q[bus.RS2];
`else
    logic unused_scoreboard_inputs;
    assign unused_scoreboard_inputs = &{1'b0, bus.Issue, bus.IssueRd, bus.RS1, bus.RS2};
    assign bus.RS1Busy = 1'b0;
    assign bus.RS2Busy = 1'b0;
`endif
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb/tb_rf_wr_arbiter.sv - self-checking bench for rf_wr_arbiter against a behavioural model
module tb_rf_wr_arbiter;
    localparam int LIMIT = 4;
`ifdef RF_ARB_SCOREBOARD_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    logic Clk;
    logic Reset_n;
    rf_wr_arbiter_if bus ();

    rf_wr_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .bus    (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: which requester owns the write port, how long the low side has waited,
    // whose turn it is on a tie, what the register file sees next, which registers await the MDU.
    bit          m_force;
    int          m_wait;
    bit          m_turn_irq;
    logic [31:0] m_busy;
    bit          m_regwr;
    logic [4:0]  m_rd;
    logic [31:0] m_wdata;

    // {irq, mdu, wb}
    function automatic logic [2:0] exp_grant();
        if (!Reset_n) return 3'b000;
        if (!m_force && bus.WbReq) return 3'b001;
        if (bus.MduReq && bus.IrqReq) return m_turn_irq ? 3'b100 : 3'b010;
        if (bus.MduReq) return 3'b010;
        if (bus.IrqReq) return 3'b100;
        return 3'b000;
    endfunction

    function automatic logic [4:0] grant_rd();
        case (exp_grant())
            3'b001:  return bus.WbRd;
            3'b010:  return bus.MduRd;
            3'b100:  return bus.IrqRd;
            default: return m_rd;
        endcase
    endfunction

    function automatic logic [31:0] grant_data();
        case (exp_grant())
            3'b001:  return bus.WbData;
            3'b010:  return bus.MduData;
            3'b100:  return bus.IrqData;
            default: return m_wdata;
        endcase
    endfunction

    function automatic int next_wait();
        logic [2:0] g;
        g = exp_grant();
        if (m_force) return 0;
        if (g[1] || g[2]) return 0;
        if (bus.MduReq || bus.IrqReq) return m_wait + 1;
        return m_wait;
    endfunction

    function automatic logic [31:0] next_busy();
        logic [31:0] nb;
        nb = m_busy;
        if (exp_grant() == 3'b010) nb[bus.MduRd] = 1'b0;
        if (bus.Issue && bus.IssueRd != 5'd0) nb[bus.IssueRd] = 1'b1;
        return nb;
    endfunction

    function automatic logic exp_busy(input logic [4:0] rs);
        return SB_EN && (rs != 5'd0) && m_busy[rs];
    endfunction

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_force    <= 1'b0;
            m_wait     <= 0;
            m_turn_irq <= 1'b0;
            m_busy     <= '0;
            m_regwr    <= 1'b0;
            m_rd       <= '0;
            m_wdata    <= '0;
        end else begin
            m_regwr    <= (exp_grant() != 3'b000) && (grant_rd() != 5'd0);
            m_rd       <= grant_rd();
            m_wdata    <= grant_data();
            m_turn_irq <= (exp_grant() == 3'b010) ? 1'b1 : (exp_grant() == 3'b100) ? 1'b0 : m_turn_irq;
            m_wait     <= next_wait();
            m_force    <= !m_force && (next_wait() == LIMIT);
            m_busy     <= next_busy();
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge Clk) begin
        check("acks", 32'({bus.IrqAck, bus.MduAck, bus.WbAck}), 32'(exp_grant()));
        check("stall", 32'(bus.Stall), 32'(m_force));
        check("regwr", 32'(bus.RegWr), 32'(m_regwr));
        if (m_regwr) begin
            check("rd", 32'(bus.RD), 32'(m_rd));
            check("wdata", bus.WData, m_wdata);
        end
        check("rs1busy", 32'(bus.RS1Busy), 32'(exp_busy(bus.RS1)));
        check("rs2busy", 32'(bus.RS2Busy), 32'(exp_busy(bus.RS2)));
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_in();
        bus.WbReq  = 1'b0;
        bus.MduReq = 1'b0;
        bus.IrqReq = 1'b0;
        bus.Issue  = 1'b0;
    endtask

    function automatic logic [3:0] obs();
        return {bus.Stall, bus.IrqAck, bus.MduAck, bus.WbAck};
    endfunction

    logic [2:0] rr_exp [3];
    logic [3:0] starve_exp [6];
    logic wa, ma, ia;

    initial begin
        rr_exp     = '{3'b010, 3'b100, 3'b010};
        starve_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b1010, 4'b0001};

        Reset_n = 1'b0;
        idle_in();
        bus.WbRd = 5'd5;  bus.WbData = 32'd0;
        bus.MduRd = 5'd0; bus.MduData = 32'd0;
        bus.IrqRd = 5'd0; bus.IrqData = 32'd0;
        bus.IssueRd = 5'd0; bus.RS1 = 5'd0; bus.RS2 = 5'd0;
        bus.WbReq = 1'b1;
        repeat (2) @(negedge Clk);
        check("rst_wback", 32'(bus.WbAck), 32'd0);
        check("rst_regwr", 32'(bus.RegWr), 32'd0);
        check("rst_stall", 32'(bus.Stall), 32'd0);
        check("rst_rd", 32'(bus.RD), 32'd0);
        check("rst_wdata", bus.WData, 32'd0);
        tick();
        Reset_n = 1'b1;
        bus.WbReq = 1'b0;

        // Write-back alone
        tick();
        bus.WbReq = 1'b1; bus.WbRd = 5'd5; bus.WbData = 32'h1234;
        @(negedge Clk);
        check("wb_ack", 32'(bus.WbAck), 32'd1);
        tick();
        bus.WbReq = 1'b0;
        @(negedge Clk);
        check("wb_regwr", 32'(bus.RegWr), 32'd1);
        check("wb_rd", 32'(bus.RD), 32'd5);
        check("wb_wdata", bus.WData, 32'h1234);
        tick();
        @(negedge Clk);
        check("wb_regwr_off", 32'(bus.RegWr), 32'd0);

        // Round robin MDU/IRQ from reset
        tick();
        bus.MduReq = 1'b1; bus.MduRd = 5'd3; bus.MduData = 32'h33;
        bus.IrqReq = 1'b1; bus.IrqRd = 5'd4; bus.IrqData = 32'h44;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check($sformatf("rr_%0d", i), 32'({bus.IrqAck, bus.MduAck, bus.WbAck}), 32'(rr_exp[i]));
            tick();
        end
        idle_in();

        // Write-back hogging the port, MDU starves then is forced through
        bus.WbReq = 1'b1; bus.WbRd = 5'd1; bus.WbData = 32'h11;
        bus.MduReq = 1'b1; bus.MduRd = 5'd8; bus.MduData = 32'h88;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            check($sformatf("starve_%0d", i), 32'(obs()), 32'(starve_exp[i]));
            if (i == 4) check("model_force", 32'(m_force), 32'd1);
            tick();
            if (i == 4) bus.MduReq = 1'b0;
        end
        idle_in();

        // IRQ write to r0: acked, no regfile write
        bus.IrqReq = 1'b1; bus.IrqRd = 5'd0; bus.IrqData = 32'hdead;
        @(negedge Clk);
        check("irq0_ack", 32'(obs()), 32'b0100);
        tick();
        bus.IrqReq = 1'b0;
        @(negedge Clk);
        check("irq0_regwr", 32'(bus.RegWr), 32'd0);

        // IRQ withdrawn exactly when the forced cycle arrives
        tick();
        bus.WbReq = 1'b1; bus.IrqReq = 1'b1; bus.IrqRd = 5'd6;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            check($sformatf("wd_wb_%0d", i), 32'(obs()), 32'b0001);
            tick();
        end
        bus.IrqReq = 1'b0;
        @(negedge Clk);
        check("wd_force", 32'(obs()), 32'b1000);
        tick();
        @(negedge Clk);
        check("wd_after", 32'(obs()), 32'b0001);
        tick();
        idle_in();

        // Scoreboard set / set-beats-clear / clear
        bus.Issue = 1'b1; bus.IssueRd = 5'd8; bus.RS1 = 5'd8;
        tick();
        bus.Issue = 1'b0;
        @(negedge Clk);
        check("sb_set", 32'(bus.RS1Busy), 32'(SB_EN));
        tick();
        bus.MduReq = 1'b1; bus.MduRd = 5'd8; bus.Issue = 1'b1; bus.IssueRd = 5'd8;
        @(negedge Clk);
        check("sb_both_ack", 32'(obs()), 32'b0010);
        tick();
        bus.MduReq = 1'b0; bus.Issue = 1'b0;
        @(negedge Clk);
        check("sb_set_wins", 32'(bus.RS1Busy), 32'(SB_EN));
        tick();
        bus.MduReq = 1'b1; bus.MduRd = 5'd8;
        @(negedge Clk);
        check("sb_clr_ack", 32'(obs()), 32'b0010);
        tick();
        bus.MduReq = 1'b0;
        @(negedge Clk);
        check("sb_clr", 32'(bus.RS1Busy), 32'd0);

        // Reset pulsed during the forced cycle
        tick();
        bus.Issue = 1'b1; bus.IssueRd = 5'd9; bus.RS2 = 5'd9;
        tick();
        bus.Issue = 1'b0;
        bus.WbReq = 1'b1; bus.MduReq = 1'b1; bus.MduRd = 5'd2; bus.MduData = 32'h22;
        for (int i = 0; i < 4; i++) tick();
        #2;
        check("pre_rst_stall", 32'(bus.Stall), 32'd1);
        check("pre_rst_busy", 32'(bus.RS2Busy), 32'(SB_EN));
        Reset_n = 1'b0;
        #1;
        check("mid_rst_stall", 32'(bus.Stall), 32'd0);
        check("mid_rst_regwr", 32'(bus.RegWr), 32'd0);
        check("mid_rst_acks", 32'(obs()), 32'd0);
        check("mid_rst_busy", 32'(bus.RS2Busy), 32'd0);
        tick();
        Reset_n = 1'b1;
        idle_in();
        @(negedge Clk);
        check("post_rst_regwr0", 32'(bus.RegWr), 32'd0);
        tick();
        @(negedge Clk);
        check("post_rst_regwr1", 32'(bus.RegWr), 32'd0);

        // Randomized traffic; requesters hold until acked, with rare withdrawals and resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge Clk);
            wa = bus.WbAck; ma = bus.MduAck; ia = bus.IrqAck;
            tick();
            if (!bus.WbReq || wa) begin
                bus.WbReq  = ($urandom_range(0, 99) < 60);
                bus.WbRd   = 5'($urandom_range(0, 7));
                bus.WbData = $urandom;
            end
            if (!bus.MduReq || ma) begin
                bus.MduReq  = ($urandom_range(0, 99) < 45);
                bus.MduRd   = 5'($urandom_range(0, 7));
                bus.MduData = $urandom;
            end else if ($urandom_range(0, 99) < 3) begin
                bus.MduReq = 1'b0;
            end
            if (!bus.IrqReq || ia) begin
                bus.IrqReq  = ($urandom_range(0, 99) < 35);
                bus.IrqRd   = 5'($urandom_range(0, 7));
                bus.IrqData = $urandom;
            end else if ($urandom_range(0, 99) < 3) begin
                bus.IrqReq = 1'b0;
            end
            bus.Issue   = ($urandom_range(0, 99) < 25);
            bus.IssueRd = 5'($urandom_range(0, 7));
            bus.RS1     = 5'($urandom_range(0, 7));
            bus.RS2     = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 499) == 0) begin
                Reset_n = 1'b0;
                #2;
                Reset_n = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rf_wr_arbiter.md
RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 The parameter list SHALL be: STARVE_LIMIT, 4, consecutive denied cycles of a pending low-priority request before a forced grant (legal 1..15).
REQ-002 The module SHALL have one clock and an asynchronous, active-low reset, with ports in this order:
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
REQ-003 Write-back requester ports SHALL be:
- WbReq  in  1  write-back stage write request.
- WbRd  in  5  destination register for WbReq.
- WbData  in  32  write data for WbReq.
- WbAck  out  1  WbReq granted this cycle.
REQ-004 Multiply/divide unit (MDU) requester ports SHALL be:
- MduReq  in  1  MDU result write request.
- MduRd  in  5  destination register for MduReq.
- MduData  in  32  write data for MduReq.
- MduAck  out  1  MduReq granted this cycle.
REQ-005 CP0/interrupt requester ports SHALL be:
- IrqReq  in  1  CP0/interrupt write request.
- IrqRd  in  5  destination register for IrqReq.
- IrqData  in  32  write data for IrqReq.
- IrqAck  out  1  IrqReq granted this cycle.
REQ-006 Remaining ports SHALL be:
- Issue  in  1  MDU operation issued.
- IssueRd  in  5  destination of the issued MDU operation.
- RS1, RS2  in  5 each  hazard query addresses.
- RS1Busy, RS2Busy  out  1 each  queried register has a pending MDU write.
- Stall  out  1  registered; freeze the pipeline write-back stage.
- RegWr  out  1  registered regfile write enable.
- RD  out  5  registered regfile write address.
- WData  out  32  registered regfile write data.

Function
REQ-007 Ack outputs SHALL be combinational and one-hot-or-zero; a requester SHALL hold Req, Rd and Data stable until its Ack.
REQ-008 A write granted in cycle N SHALL appear on RegWr/RD/WData in cycle N+1 for exactly one cycle; with no grant, RegWr SHALL be 0 in N+1.
REQ-009 A granted write with Rd==0 SHALL be acked, but RegWr SHALL stay 0.
REQ-010 The FSM SHALL have two states, NORMAL and FORCE.
REQ-011 In NORMAL, WbReq SHALL win unconditionally; otherwise MDU vs IRQ SHALL be resolved by a 1-bit round-robin pointer.
REQ-012 The round-robin pointer SHALL toggle to the other requester after each MDU or IRQ grant and hold otherwise.
REQ-013 A 4-bit starve counter SHALL increment each cycle (MduReq|IrqReq) is pending and neither is acked, and clear on any MDU/IRQ grant.
REQ-014 When the counter reaches STARVE_LIMIT in NORMAL, the next state SHALL be FORCE, with Stall registered to 1 for that cycle.
REQ-015 In FORCE, WbAck SHALL be 0 and the round-robin winner among MDU/IRQ SHALL be granted.
REQ-016 FORCE SHALL last exactly one cycle, return to NORMAL, and clear the counter.
REQ-017 If the low-priority request is withdrawn before FORCE, FORCE SHALL still last one cycle, with no grant and the counter cleared.
REQ-018 Scoreboard: Issue with IssueRd!=0 SHALL set Busy[IssueRd] at the clock edge.
REQ-019 Scoreboard: an MduAck SHALL clear Busy[MduRd].
REQ-020 Scoreboard: on the same register in the same cycle, set SHALL win over clear.
REQ-021 RSxBusy SHALL equal Busy[RSx] combinationally, and SHALL always be 0 for RSx==0.

Reset
REQ-022 Asserting Reset_n low SHALL asynchronously force RegWr=0, RD=0, WData=0, Stall=0, Busy=all 0, counter=0, pointer=MDU, state=NORMAL.
REQ-023 Reset mid-FORCE or mid-write SHALL discard the pending write, with no RegWr after deassertion until a new grant.
REQ-024 Ack outputs SHALL be 0 while Reset_n is low.

Configuration
REQ-025 With RF_ARB_SCOREBOARD_EN defined, the Busy scoreboard SHALL be built (REQ-018 to REQ-021).
REQ-026 Without RF_ARB_SCOREBOARD_EN, no Busy storage SHALL exist, RS1Busy/RS2Busy SHALL be tied 0, and Issue/IssueRd SHALL be ignored; arbitration SHALL be unchanged.

Verification
REQ-027 WbReq=1, WbRd=5, WbData=0x1234 alone -> WbAck same cycle; next cycle RegWr=1, RD=5, WData=0x1234.
REQ-028 MduReq and IrqReq held together, no WbReq -> grants alternate MDU, IRQ, MDU from reset.
REQ-029 WbReq held high with MduReq pending, STARVE_LIMIT=4 -> 4 cycles WbAck, 1 cycle Stall=1 with MduAck, then WbAck resumes.
REQ-030 IrqReq with IrqRd=0 -> IrqAck=1, RegWr stays 0.
REQ-031 Issue with IssueRd=8, RS1=8 -> RS1Busy=1 until MduAck with MduRd=8; simultaneous Issue and MduAck to reg 8 -> RS1Busy stays 1; without the macro, always 0.
REQ-032 Reset_n pulsed low during FORCE -> Stall=0 and RegWr=0 immediately; Busy cleared.
